// File: rtl/apb_uart_tx_sched.sv
// APB master for the apb_uart slave port. It configures the UART after reset,
// then shares the TX data register between two byte requesters using
// round-robin arbitration. After each byte it waits long enough for the frame
// to finish before it writes the next byte.
module apb_uart_tx_sched #(
  parameter int BAUD_DIV   = 16,
  parameter int GAP_CYCLES = 200
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  output logic        req1_ready,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [7:0]  PADDR,
  output logic [31:0] PWDATA,
  input  logic        PREADY,
  output logic        cfg_done,
  output logic        busy,
  output logic        grant_id
);

  localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    CFG_EN,
    CFG_BAUD,
    IDLE,
    XFER,
    GAP
  } state_t;

  state_t        state;
  logic          last;
  logic [CW-1:0] gap_cnt;
  logic          pick1;

  // Requester 1 wins when it is the only one asking, or when both ask and
  // requester 0 was served last.
  assign pick1 = req1_valid && (!req0_valid || !last);

  // Main controller: configuration writes, arbitration, TX writes and the
  // post-write hold-off. Every output is registered here.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state      <= CFG_EN;
      last       <= 1'b1;
      gap_cnt    <= '0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= 8'h00;
      PWDATA     <= 32'h0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      cfg_done   <= 1'b0;
      busy       <= 1'b1;
      grant_id   <= 1'b0;
    end else begin
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      case (state)
        CFG_EN, CFG_BAUD: begin
          if (!PSEL) begin
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b1;
            PADDR   <= (state == CFG_BAUD) ? 8'h04 : 8'h00;
            PWDATA  <= (state == CFG_BAUD) ? 32'(BAUD_DIV) : 32'h1;
          end else if (!PENABLE) begin
            PENABLE <= 1'b1;
          end else if (PREADY) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            if (state == CFG_EN) begin
              state <= CFG_BAUD;
            end else begin
              state    <= IDLE;
              cfg_done <= 1'b1;
              busy     <= 1'b0;
            end
          end
        end
        IDLE: begin
          if (req0_valid || req1_valid) begin
            state      <= XFER;
            busy       <= 1'b1;
            last       <= pick1;
            grant_id   <= pick1;
            req0_ready <= !pick1;
            req1_ready <= pick1;
            PSEL       <= 1'b1;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b1;
            PADDR      <= 8'h08;
            PWDATA     <= {24'h0, pick1 ? req1_data : req0_data};
          end
        end
        XFER: begin
          if (!PENABLE) begin
            PENABLE <= 1'b1;
          end else if (PREADY) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            gap_cnt <= CW'(GAP_CYCLES - 1);
            state   <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          state <= CFG_EN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_uart_tx_sched.sv
// Self-checking bench for apb_uart_tx_sched. A timeline model predicts every
// cycle of the APB and handshake outputs from the bench-driven inputs, and a
// separate monitor checks each completed APB write against a scoreboard queue.
module tb_apb_uart_tx_sched;

  localparam int GAP  = 200;
  localparam int BAUD = 16;
  localparam int INF  = 1000000000;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        req0_valid, req1_valid;
  logic [7:0]  req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        PSEL, PENABLE, PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic        PREADY;
  logic        cfg_done, busy, grant_id;

  apb_uart_tx_sched #(.BAUD_DIV(BAUD), .GAP_CYCLES(GAP)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PREADY(PREADY),
    .cfg_done(cfg_done), .busy(busy), .grant_id(grant_id)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  g_cyc[$];
  bit  g_id[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int last_acc_len = 0;
  int last_wr_cyc = 0;
  int wr_count = 0;

  // Cycle counter: cycle k is the interval after the k-th rising edge.
  initial forever begin
    @(posedge PCLK);
    cyc++;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Timeline reference model. It tracks when the pending APB write reaches
  // its access phase, when the master is free again, and who wins each grant.
  initial begin
    int  m_pending;
    int  m_access_start;
    int  m_idle_from;
    int  m_cfg_from;
    bit  m_last, m_r0, m_r1, m_gid, m_in_reset, w, exp_psel;
    m_pending = 0; m_access_start = INF; m_idle_from = INF; m_cfg_from = INF;
    m_last = 1'b1; m_r0 = 1'b0; m_r1 = 1'b0; m_gid = 1'b0; m_in_reset = 1'b1;
    forever begin
      @(negedge PCLK);
      if (PRESET) begin
        check_output("rst_psel", 32'(PSEL), 32'd0);
        check_output("rst_penable", 32'(PENABLE), 32'd0);
        check_output("rst_pwrite", 32'(PWRITE), 32'd0);
        check_output("rst_paddr", 32'(PADDR), 32'd0);
        check_output("rst_pwdata", PWDATA, 32'd0);
        check_output("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
        check_output("rst_cfg_done", 32'(cfg_done), 32'd0);
        check_output("rst_grant_id", 32'(grant_id), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd1);
        m_in_reset = 1'b1; m_pending = 0; m_idle_from = INF; m_cfg_from = INF;
        m_last = 1'b1; m_r0 = 1'b0; m_r1 = 1'b0; m_gid = 1'b0;
      end else begin
        if (m_in_reset) begin
          m_in_reset = 1'b0;
          m_pending = 1;
          m_access_start = cyc + 2;
          exp_q.delete();
          exp_q.push_back('{addr: 8'h00, data: 32'h1});
          exp_q.push_back('{addr: 8'h04, data: 32'(BAUD)});
        end
        exp_psel = (m_pending != 0) && (cyc >= m_access_start - 1);
        check_output("psel", 32'(PSEL), 32'(exp_psel));
        check_output("penable", 32'(PENABLE), 32'((m_pending != 0) && (cyc >= m_access_start)));
        if (exp_psel) check_output("pwrite", 32'(PWRITE), 32'd1);
        check_output("busy", 32'(busy), 32'(!((m_pending == 0) && (cyc >= m_idle_from))));
        check_output("cfg_done", 32'(cfg_done), 32'(cyc >= m_cfg_from));
        check_output("req0_ready", 32'(req0_ready), 32'(m_r0));
        check_output("req1_ready", 32'(req1_ready), 32'(m_r1));
        check_output("grant_id", 32'(grant_id), 32'(m_gid));
        m_r0 = 1'b0;
        m_r1 = 1'b0;
        if ((m_pending != 0) && (cyc >= m_access_start) && PREADY) begin
          if (m_pending == 1) begin
            m_pending = 2;
            m_access_start = cyc + 3;
          end else if (m_pending == 2) begin
            m_pending = 0;
            m_idle_from = cyc + 1;
            m_cfg_from = cyc + 1;
          end else begin
            m_pending = 0;
            m_idle_from = cyc + GAP + 1;
          end
        end else if ((m_pending == 0) && (cyc >= m_idle_from) && (req0_valid || req1_valid)) begin
          w = (req0_valid && req1_valid) ? !m_last : req1_valid;
          exp_q.push_back('{addr: 8'h08, data: {24'h0, w ? req1_data : req0_data}});
          m_last = w;
          m_gid = w;
          m_r0 = !w;
          m_r1 = w;
          m_pending = 3;
          m_access_start = cyc + 2;
          m_idle_from = INF;
        end
      end
    end
  end

  // Monitor: protocol stability during access and scoreboard comparison of
  // every write the DUT completes.
  initial begin
    logic        prev_psel;
    logic [7:0]  prev_addr;
    logic [31:0] prev_data;
    int          acc_len;
    wr_t         e;
    prev_psel = 1'b0; prev_addr = 8'h0; prev_data = 32'h0; acc_len = 0;
    forever begin
      @(negedge PCLK);
      if (PRESET) begin
        acc_len = 0;
      end else begin
        if (req0_ready || req1_ready) begin
          g_cyc.push_back(cyc);
          g_id.push_back(req1_ready);
        end
        if (PENABLE) begin
          check_output("access_prev_psel", 32'(prev_psel), 32'd1);
          check_output("paddr_stable", 32'(PADDR), 32'(prev_addr));
          check_output("pwdata_stable", PWDATA, prev_data);
          acc_len++;
        end
        if (PSEL && PENABLE && PREADY) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_write: got addr %0h data %0h, expected no write", PADDR, PWDATA);
          end else begin
            e = exp_q.pop_front();
            check_output("write_addr", 32'(PADDR), 32'(e.addr));
            check_output("write_data", PWDATA, e.data);
          end
          last_acc_len = acc_len;
          acc_len = 0;
          last_wr_cyc = cyc;
          wr_count++;
        end
      end
      prev_psel = PSEL;
      prev_addr = PADDR;
      prev_data = PWDATA;
    end
  end

  task automatic wait_ready(input int which, input int limit, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < limit; n++) begin
      tick();
      if ((which == 0 && req0_ready) || (which == 1 && req1_ready)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < limit; n++) begin
      tick();
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic apply_stimulus(input int cycles);
    for (int n = 0; n < cycles; n++) begin
      tick();
      PREADY = ($urandom_range(0, 3) != 0);
      if (req0_valid && req0_ready) req0_valid = 1'b0;
      else if (!req0_valid && ($urandom_range(0, 7) == 0)) begin
        req0_valid = 1'b1;
        req0_data = 8'($urandom);
      end else if (req0_valid && ($urandom_range(0, 63) == 0)) req0_valid = 1'b0;
      if (req1_valid && req1_ready) req1_valid = 1'b0;
      else if (!req1_valid && ($urandom_range(0, 7) == 0)) begin
        req1_valid = 1'b1;
        req1_data = 8'($urandom);
      end else if (req1_valid && ($urandom_range(0, 63) == 0)) req1_valid = 1'b0;
    end
  endtask

  // Directed scenarios followed by a randomized phase and a drain.
  initial begin
    int rel_cyc;
    int n;
    int wr_before;
    bit ok;
    PRESET = 1'b1; PREADY = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_data = 8'h0; req1_data = 8'h0;
    repeat (3) tick();
    PRESET = 1'b0;
    rel_cyc = cyc;
    n = 0;
    while (!cfg_done && n < 50) begin tick(); n++; end
    check_output("cfg_done_latency", 32'(cyc - rel_cyc), 32'd6);

    // Both requesters held continuously: strict alternation, fixed spacing.
    repeat (2) tick();
    g_cyc.delete(); g_id.delete();
    req0_valid = 1'b1; req0_data = 8'hA1;
    req1_valid = 1'b1; req1_data = 8'hB2;
    n = 0;
    while (g_id.size() < 4 && n < 1500) begin tick(); n++; end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check_output("rr_grant_count", 32'(g_id.size()), 32'd4);
    if (g_id.size() >= 4) begin
      for (int i = 0; i < 4; i++) check_output("rr_grant_id", 32'(g_id[i]), 32'(i % 2));
      for (int i = 1; i < 4; i++) check_output("rr_spacing", 32'(g_cyc[i] - g_cyc[i-1]), 32'(3 + GAP));
    end
    wait_idle(500, ok);
    check_output("rr_idle_timeout", 32'(ok), 32'd1);

    // Single requester byte.
    repeat (3) tick();
    req0_valid = 1'b1; req0_data = 8'h55;
    wait_ready(0, 20, ok);
    req0_valid = 1'b0;
    check_output("single_ready_timeout", 32'(ok), 32'd1);
    wait_idle(500, ok);
    check_output("single_idle_timeout", 32'(ok), 32'd1);

    // Five wait states during a TX write.
    req0_valid = 1'b1; req0_data = 8'h77;
    wait_ready(0, 20, ok);
    req0_valid = 1'b0;
    PREADY = 1'b0;
    check_output("wait_ready_timeout", 32'(ok), 32'd1);
    repeat (6) tick();
    PREADY = 1'b1;
    repeat (2) tick();
    check_output("wait_access_len", 32'(last_acc_len), 32'd6);
    wait_idle(500, ok);
    check_output("wait_idle_timeout", 32'(ok), 32'd1);

    // Request arriving in the hold-off window.
    wr_before = wr_count;
    req0_valid = 1'b1; req0_data = 8'h11;
    wait_ready(0, 20, ok);
    req0_valid = 1'b0;
    n = 0;
    while (wr_count == wr_before && n < 20) begin tick(); n++; end
    check_output("gap_write_seen", 32'(wr_count - wr_before), 32'd1);
    repeat (10) tick();
    req1_valid = 1'b1; req1_data = 8'h3C;
    wait_ready(1, 400, ok);
    req1_valid = 1'b0;
    check_output("gap_ready_timeout", 32'(ok), 32'd1);
    check_output("gap_grant_cycle", 32'(cyc - last_wr_cyc), 32'(GAP + 2));
    wait_idle(500, ok);

    // Reset during the baud divisor access.
    PRESET = 1'b1;
    tick();
    PRESET = 1'b0;
    n = 0;
    while (!(PSEL && PENABLE && PADDR == 8'h04) && n < 20) begin tick(); n++; end
    check_output("baud_access_seen", 32'(n < 20), 32'd1);
    PRESET = 1'b1;
    #1;
    check_output("midrst_psel", 32'(PSEL), 32'd0);
    check_output("midrst_penable", 32'(PENABLE), 32'd0);
    check_output("midrst_cfg_done", 32'(cfg_done), 32'd0);
    repeat (2) tick();
    PRESET = 1'b0;
    n = 0;
    while (!cfg_done && n < 50) begin tick(); n++; end
    check_output("recfg_done", 32'(cfg_done), 32'd1);

    // Randomized traffic with random wait states and withdrawals.
    apply_stimulus(5000);

    // Drain outstanding writes.
    req0_valid = 1'b0; req1_valid = 1'b0; PREADY = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 2000) begin tick(); n++; end
    check_output("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    check_output("drain_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_uart_tx_sched.md
Name: apb_uart_tx_sched

Overview:
- APB master that owns the apb_uart slave port.
- After reset it programs the UART: control register 0x00 = 1 (enable), baud divisor register 0x04 = BAUD_DIV.
- It then shares the TX data register (0x08) between two byte requesters using round-robin arbitration.
- It holds off each new byte for GAP_CYCLES after the previous write so a frame is never overwritten mid-transmission.

Parameters:
- BAUD_DIV, 16: value written to 0x04 during configuration.
- GAP_CYCLES, 200: PCLK cycles waited after each TX data write completes; must be ≥1 and ≥ the UART frame time.

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has a byte.
- req0_data  in  8  requester 0 byte.
- req0_ready  out  1  1-cycle pulse: req0 byte accepted.
- req1_valid  in  1  requester 1 has a byte.
- req1_data  in  8  requester 1 byte.
- req1_ready  out  1  1-cycle pulse: req1 byte accepted.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB write (always 1 when PSEL=1).
- PADDR  out  8  APB address.
- PWDATA  out  32  APB write data.
- PREADY  in  1  APB slave ready.
- cfg_done  out  1  high once both config writes have completed.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  1  requester owning the current or last transfer.

Behaviour:
- Reset (async assert, sync release) values:
  - All outputs 0: PSEL, PENABLE, PWRITE, PADDR, PWDATA, reqN_ready, cfg_done, grant_id.
  - busy = 1.
  - Round-robin pointer last = 1, so req0 wins the first tie.
  - State = CFG_EN.
- State machine: CFG_EN → CFG_BAUD → IDLE → XFER → GAP → IDLE.
- Each APB write uses one SETUP/ACCESS pair:
  - SETUP cycle: PSEL=1, PENABLE=0, PWRITE=1, PADDR/PWDATA valid.
  - ACCESS cycles: PENABLE=1. Held until a rising edge sees PREADY=1.
  - Following cycle: PSEL=PENABLE=0.
  - PADDR/PWDATA remain stable through SETUP and ACCESS; they hold their last value when idle.
- Configuration sequence:
  - CFG_EN: write 0x00 ← 32'h1.
  - CFG_BAUD: write 0x04 ← BAUD_DIV (zero-extended).
  - cfg_done rises the cycle after the BAUD access completes and stays 1 until reset.
- IDLE arbitration:
  - One valid requester: grant it.
  - Both valid: grant the requester ≠ last.
  - On grant: pulse reqN_ready for exactly one cycle, latch data, set grant_id and last, go to XFER.
  - No valid requester: stay in IDLE, busy=0.
- XFER:
  - APB write 0x08 ← {24'h0, latched byte}.
  - The byte is latched, so requester inputs may change after its ready pulse.
- GAP:
  - Counter loads GAP_CYCLES-1 on entry and decrements to 0.
  - Returns to IDLE after exactly GAP_CYCLES cycles in GAP.
- Throughput:
  - Grant cycle → SETUP next cycle.
  - With PREADY always 1: grant-to-grant spacing = 1 (IDLE) + 2 (APB) + GAP_CYCLES cycles.
- Requester handshake:
  - Valid must be held until ready; deasserting it before grant withdraws the request with no side effect.
  - A requester's ready never pulses without a subsequent 0x08 write of its byte.
- PREADY low: wait states extend ACCESS indefinitely; there is no timeout.
- Reset mid-operation: PSEL/PENABLE drop immediately (async); after release the configuration sequence repeats from CFG_EN.
- Simultaneous events:
  - A request arriving during XFER or GAP waits; it is never lost while valid is held.
  - Only one ready pulses per grant.

Test Plan:
- Reset release, PREADY=1, no requests:
  - writes 0x00←1 then 0x04←16, each exactly 1 SETUP + 1 ACCESS cycle.
  - cfg_done=1 two cycles after second SETUP; busy=0 thereafter.
- req0_valid with data 8'h55 after cfg_done:
  - req0_ready pulses 1 cycle.
  - Next cycle SETUP with PADDR=0x08, PWDATA=0x55.
  - busy low again exactly GAP_CYCLES cycles after ACCESS completes.
- req0 (0xA1) and req1 (0xB2) held continuously:
  - Writes alternate 0xA1, 0xB2, 0xA1, 0xB2.
  - grant_id alternates 0,1,0,1.
  - Grant spacing = 3+GAP_CYCLES with GAP_CYCLES=200.
- PREADY forced low 5 cycles during XFER:
  - PSEL/PENABLE/PADDR/PWDATA held stable for the 5 wait cycles.
  - Transfer completes on the first PREADY=1 edge.
  - GAP starts the cycle after.
- Request arriving during GAP (req1=0x3C):
  - No ready pulse until GAP ends.
  - Granted on the first IDLE cycle.
  - Written as 0x3C.
- PRESET asserted during CFG_BAUD ACCESS:
  - PSEL=0, cfg_done=0 immediately.
  - After release, 0x00←1 is reissued before 0x04←16.
